// File: rtl/mips_pkg.sv
// Shared TinyTout MIPS definitions: opcodes, ALU op codes, control-bus bit
// positions, fetch FSM state encoding and the branch-offset helper.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam int unsigned CTRL_JUMP_BIT = 1;
  localparam int unsigned CTRL_BEQ_BIT  = 2;
  localparam int unsigned CTRL_BNE_BIT  = 3;

  localparam logic [2:0] RESET_S = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] DECODE  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  // Word offset of a branch immediate, sign-extended to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_unit.sv
// Combinational next-PC selection: jump, taken BEQ/BNE, or sequential pc+4.
module branch_target_unit
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        ctrl_jump,
  input  logic        ctrl_beq,
  input  logic        ctrl_bne,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic [31:0] p4;
  logic [31:0] br_target;
  logic        unused_opcode;

  assign p4            = pc + 32'd4;
  assign br_target     = p4 + branch_offset(ir[15:0]);
  assign unused_opcode = ^ir[31:26];

  // NOTE: next_pc is assigned on every path, so no latch is inferred.
  always_comb begin
    if (ctrl_jump)                  next_pc = {p4[31:28], ir[25:0], 2'b00};
    else if (ctrl_beq && alu_zero)  next_pc = br_target;
    else if (ctrl_bne && !alu_zero) next_pc = br_target;
    else                            next_pc = p4;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC and IR, fetches from instruction
// memory, hands the opcode to the control unit and retires instructions.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic        ir_valid,
  input  logic        ctrl_jump,
  input  logic        ctrl_beq,
  input  logic        ctrl_bne,
  input  logic        alu_zero,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [31:0] retired
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] next_pc;

  branch_target_unit u_btu (
    .pc        (pc_q),
    .ir        (ir_q),
    .ctrl_jump (ctrl_jump),
    .ctrl_beq  (ctrl_beq),
    .ctrl_bne  (ctrl_bne),
    .alu_zero  (alu_zero),
    .next_pc   (next_pc)
  );

  // NOTE: every next-state signal takes its hold value first, then the case
  // overrides only what changes; this keeps the block free of latches.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    err_d     = err_q;
    retired_d = retired_q;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = DECODE;
        end else begin
          wait_d = wait_q + 32'd1;
          if (TIMEOUT != 0 && wait_d == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          state_d   = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RESET_S;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_S;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign ir_valid  = (state_q == DECODE);
  assign ir        = ir_q;
  assign opcode    = ir_q[31:26];
  assign pc        = pc_q;
  assign fetch_err = err_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (TIMEOUT set to 4).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic        ir_valid;
  logic        ctrl_jump = 1'b0;
  logic        ctrl_beq  = 1'b0;
  logic        ctrl_bne  = 1'b0;
  logic        alu_zero  = 1'b0;
  logic        stall     = 1'b0;
  logic [31:0] pc;
  logic        fetch_err;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .opcode     (opcode),
    .ir_valid   (ir_valid),
    .ctrl_jump  (ctrl_jump),
    .ctrl_beq   (ctrl_beq),
    .ctrl_bne   (ctrl_bne),
    .alu_zero   (alu_zero),
    .stall      (stall),
    .pc         (pc),
    .fetch_err  (fetch_err),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From FETCH: immediate ready, then EXEC exit with the given control bits.
  task automatic run_instr(input logic [31:0] word, input logic j, input logic b,
                           input logic n, input logic z);
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    imem_ready = 1'b0;
    step();
    ctrl_jump = j; ctrl_beq = b; ctrl_bne = n; alu_zero = z;
    step();
    ctrl_jump = 1'b0; ctrl_beq = 1'b0; ctrl_bne = 1'b0; alu_zero = 1'b0;
  endtask

  initial begin
    step();
    step();
    check("rst_pc",       pc,               32'h0);
    check("rst_ir",       ir,               32'h0);
    check("rst_opcode",   {26'd0, opcode},  32'h0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'h0);
    check("rst_req",      {31'd0, imem_req}, 32'h0);
    check("rst_err",      {31'd0, fetch_err}, 32'h0);
    check("rst_retired",  retired,          32'h0);

    rst = 1'b0;
    step();
    check("first_req",  {31'd0, imem_req}, 32'h1);
    check("first_addr", imem_addr,          32'h0);

    // ADDI at 0
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ready = 1'b0;
    check("addi_ir_valid", {31'd0, ir_valid}, 32'h1);
    check("addi_opcode",   {26'd0, opcode},   32'h8);
    check("addi_ir",       ir,                32'h2008_0005);
    step();
    check("exec_ir_valid", {31'd0, ir_valid}, 32'h0);
    check("exec_req",      {31'd0, imem_req}, 32'h0);
    step();
    check("seq_req",     {31'd0, imem_req}, 32'h1);
    check("seq_addr",    imem_addr,         32'h4);
    check("seq_retired", retired,           32'h1);

    run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0);
    check("j_to_10", imem_addr, 32'h10);

    run_instr(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    check("beq_taken", imem_addr, 32'h10);
    check("beq_retired", retired, 32'h3);

    run_instr(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    check("beq_not_taken", imem_addr, 32'h14);

    run_instr(32'h1400_000A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("bne_taken", imem_addr, 32'h40);

    run_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1, 1'b1);
    check("jump_wins", imem_addr, 32'h400);

    run_instr(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("unknown_p4", imem_addr, 32'h404);
    check("unknown_retired", retired, 32'h7);

    // Stall for 4 EXEC cycles
    imem_ready = 1'b1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ready = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_req",     {31'd0, imem_req}, 32'h0);
      check("stall_pc",      pc,                32'h404);
      check("stall_ir",      ir,                32'h2008_0005);
      check("stall_retired", retired,           32'h7);
    end
    stall = 1'b0;
    step();
    check("stall_release_pc",      imem_addr, 32'h408);
    check("stall_release_retired", retired,   32'h8);

    // Three wait cycles, ready on the fourth FETCH cycle: no timeout
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req",  {31'd0, imem_req},  32'h1);
      check("wait_addr", imem_addr,          32'h408);
      check("wait_err",  {31'd0, fetch_err}, 32'h0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_ready = 1'b0;
    check("late_ready_valid", {31'd0, ir_valid},  32'h1);
    check("late_ready_err",   {31'd0, fetch_err}, 32'h0);
    step();
    step();
    check("late_ready_next", imem_addr, 32'h40C);

    // Timeout: four FETCH cycles without ready
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_pending_err", {31'd0, fetch_err}, 32'h0);
    end
    step();
    check("to_err", {31'd0, fetch_err}, 32'h1);
    check("to_req", {31'd0, imem_req},  32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    check("halt_req",      {31'd0, imem_req}, 32'h0);
    check("halt_ir",       ir,                32'h0000_0020);
    check("halt_ir_valid", {31'd0, ir_valid}, 32'h0);

    // Reset out of HALT with a response on the bus: it must be ignored
    rst = 1'b1;
    step();
    check("rerst_err",     {31'd0, fetch_err}, 32'h0);
    check("rerst_ir",      ir,                 32'h0);
    check("rerst_pc",      pc,                 32'h0);
    check("rerst_retired", retired,            32'h0);
    imem_ready = 1'b0;
    rst = 1'b0;
    step();
    check("restart_req",  {31'd0, imem_req}, 32'h1);
    check("restart_addr", imem_addr,         32'h0);

    // PC wrap: branch back to 0xFFFF_FFFC, then sequential wraps to 0
    run_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    check("wrap_branch", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_zero",    imem_addr, 32'h0);
    check("wrap_retired", retired,   32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch and sequencing front end for the TinyTout MIPS core. Owns the PC, requests instruction words from instruction memory, and presents the opcode field to `control_unit_module` on its `control_signal` input. It consumes the registered jump/branch control bits that come back from the control unit, together with the ALU zero flag, to pick the next PC. It is the initiator side of the opcode → control-bus decode path.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `TIMEOUT`, default 255: maximum consecutive FETCH cycles without `imem_ready`. 0 disables the timeout.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: byte address of the fetch, always equal to `pc`.
- `imem_ready` in 1: `imem_rdata` is valid this cycle.
- `imem_rdata` in 32: instruction word.
- `ir` out 32: current instruction register.
- `opcode` out 6: `ir[31:26]`, drives the control unit's `control_signal`.
- `ir_valid` out 1: one-cycle pulse in DECODE.
- `ctrl_jump`, `ctrl_beq`, `ctrl_bne` in 1 each: control-bus bits 1, 2 and 3 from the control unit.
- `alu_zero` in 1: ALU zero flag for the branch compare.
- `stall` in 1: holds the unit in EXEC.
- `pc` out 32: address of the current instruction.
- `fetch_err` out 1: sticky timeout flag.
- `retired` out 32: count of completed instructions.

## Operation
- States:
  - RESET_S
  - FETCH
  - DECODE
  - EXEC
  - HALT
- RESET_S → FETCH unconditionally.
- FETCH:
  - `imem_req`=1.
  - `imem_ready`=1: capture `ir`←`imem_rdata`, clear the wait counter, go to DECODE.
  - Otherwise increment the wait counter. When `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, set `fetch_err` and go to HALT.
- DECODE:
  - `ir_valid`=1.
  - The control unit registers its decode on this edge.
  - Go to EXEC.
- EXEC:
  - Control bits are valid.
  - `stall`=1: hold; `ir`, `pc` and `opcode` stay unchanged.
  - Otherwise load `pc`←next_pc, increment `retired`, go to FETCH.
- HALT: `imem_req`=0. Remains in HALT until `rst`.
- next_pc, with p4 = pc+4. Priority order:
  1. `ctrl_jump` (J/JAL): {p4[31:28], ir[25:0], 2'b00}.
  2. `ctrl_beq` & `alu_zero`: p4 + (sext(ir[15:0])<<2).
  3. `ctrl_bne` & !`alu_zero`: same target as item 2.
  4. Otherwise p4.
- All PC arithmetic is modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- Unknown opcodes decode to an all-zero control bus, so they fall through to p4.
- `retired` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values:
  - `pc`=RESET_PC
  - `ir`=0
  - `opcode`=0
  - `ir_valid`=0
  - `imem_req`=0
  - `fetch_err`=0
  - `retired`=0
  - state=RESET_S
- First `imem_req` appears 1 cycle after `rst` deasserts.
- `rst` asserted in any state, including mid-fetch, stall or HALT, aborts the operation; the pending memory response is ignored.
- Minimum 3 cycles per instruction (FETCH, DECODE, EXEC); each FETCH cycle waiting on `imem_ready` adds 1.
- `imem_ready` is sampled only in FETCH and ignored in all other states.
- `stall` is sampled only in EXEC.
- `alu_zero` and the `ctrl_*` inputs are sampled on the EXEC exit edge.
- `imem_addr` is stable for the whole FETCH dwell.

## Structure
- Shared package `mips_pkg`:
  - opcode constants
  - ALU op codes
  - control-bus bit indices
  - fetch-state encoding
- Combinational sub-module `branch_target_unit`: inputs pc, ir and the control/zero bits; output next_pc.
- The FSM, wait counter and retire counter live in the top level.

## Test plan
- Reset: `rst` high for 2 cycles → `pc`=0, `ir_valid`=0, `imem_req`=0. `imem_req`=1 with `imem_addr`=0 exactly 1 cycle after release.
- Sequential: immediate ready with word 0x20080005 (ADDI) → `opcode`=8 and one `ir_valid` pulse. Next `imem_addr`=0x4, 3 cycles after the previous request; `retired`=1.
- Branch at `pc`=0x10 with `ir`=0x1000FFFF:
  - `ctrl_beq`=1, `alu_zero`=1 → next fetch at 0x10.
  - `alu_zero`=0 → next fetch at 0x14.
- Jump at `pc`=0x40 with `ir`=0x08000100 and `ctrl_jump`=1 (both branch bits also driven high) → next fetch at 0x400; jump wins.
- Stall: `stall`=1 for 4 EXEC cycles → `imem_req` stays 0, `pc`/`ir` are stable, and `retired` increments once, after release.
- Timeout: `TIMEOUT`=4 and `imem_ready` held at 0 → `fetch_err`=1 after the 4th FETCH cycle, with `imem_req`=0 thereafter. `rst` clears the flag and fetching restarts at RESET_PC.
